// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front end.
// - state_t : step encoding shown on the LEDs (A, B, OP, ISSUE).
// - Opcode constants shared with the ALU so both sides agree on meaning.
package alu_pkg;

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_OP    = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    localparam logic [2:0] ADD   = 3'd0;
    localparam logic [2:0] SUB   = 3'd1;
    localparam logic [2:0] AND   = 3'd2;
    localparam logic [2:0] OR    = 3'd3;
    localparam logic [2:0] XOR   = 3'd4;
    localparam logic [2:0] NOT_A = 3'd5;
    localparam logic [2:0] SHL   = 3'd6;
    localparam logic [2:0] SHR   = 3'd7;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Board-side and ALU-side signals of the operand loader.
// - sw, btn        : raw slide switches and push-button (asynchronous)
// - a, b, op       : committed operands and opcode
// - out_valid/ready: request handshake towards the ALU stage
// - state          : current step for the LEDs
// master = the loader; slave = whoever drives the switches/button and
// consumes the request (the ALU stage, or a testbench).
interface alu_operand_loader_if #(
    parameter int WIDTH    = 4,
    parameter int OP_WIDTH = 3
);
    logic [WIDTH-1:0]    sw;
    logic                btn;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [OP_WIDTH-1:0] op;
    logic                out_valid;
    logic                out_ready;
    logic [1:0]          state;

    modport master (
        input  sw, btn, out_ready,
        output a, b, op, out_valid, state
    );

    modport slave (
        output sw, btn, out_ready,
        input  a, b, op, out_valid, state
    );
endinterface

// File: rtl/alu_operand_loader_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debouncer and rising-edge
// detector. Produces a single-cycle press pulse per accepted press.
// - clk, rst : clock and synchronous active-high reset
// - btn      : raw, bouncy push-button
// - press    : one-cycle pulse on each debounced rising edge
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_meta_q;
    logic             btn_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             db_dly_q;     // db delayed one cycle

    // The level must differ from db for DEBOUNCE_CYCLES consecutive cycles;
    // any return to db restarts the count, so short glitches never land.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        cnt_d = cnt_q;
        db_d  = db_q;
        if (btn_s_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = btn_s_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value, independent of statement order.
        if (rst) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            cnt_q      <= '0;
            db_q       <= 1'b0;
            db_dly_q   <= 1'b0;
        end else begin
            btn_meta_q <= btn;
            btn_s_q    <= btn_meta_q;
            cnt_q      <= cnt_d;
            db_q       <= db_d;
            db_dly_q   <= db_q;
        end
    end

    assign press = db_q & ~db_dly_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Operand loader for the board ALU. The user commits A, B and the opcode in
// turn from the slide switches, one button press each; the completed request
// is then held stable and offered to the ALU with valid/ready.
// - clk, rst : clock and synchronous active-high reset
// - bus      : switches, button, committed a/b/op, handshake and LED state
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int OP_WIDTH        = 3,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_operand_loader_if.master  bus
);

    logic                press;
    logic [WIDTH-1:0]    sw_meta_q;
    logic [WIDTH-1:0]    sw_s_q;
    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [OP_WIDTH-1:0] op_q, op_d;
    logic                out_valid_q, out_valid_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn),
        .press (press)
    );

    // Values are captured from the synchronised switches, which lag the
    // raw switches by two cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q <= '0;
            sw_s_q    <= '0;
        end else begin
            sw_meta_q <= bus.sw;
            sw_s_q    <= sw_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            S_A: if (press) begin
                a_d     = sw_s_q;
                state_d = S_B;
            end
            S_B: if (press) begin
                b_d     = sw_s_q;
                state_d = S_OP;
            end
            S_OP: if (press) begin
                op_d        = sw_s_q[OP_WIDTH-1:0];
                out_valid_d = 1'b1;
                state_d     = S_ISSUE;
            end
            // Presses are ignored here; only the ALU accepting the request
            // moves on. a/b/op keep their values for the next sequence.
            S_ISSUE: if (bus.out_ready) begin
                out_valid_d = 1'b0;
                state_d     = S_A;
            end
            default: state_d = S_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_A;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.op        = op_q;
    assign bus.out_valid = out_valid_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with DEBOUNCE_CYCLES=4.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, so each observation reflects the edge just taken.
module tb_alu_operand_loader;

    localparam int WIDTH    = 4;
    localparam int OP_WIDTH = 3;
    localparam int DB       = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors    = 0;
    int   miscompares = 0;

    alu_operand_loader_if #(.WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH)) bus ();

    alu_operand_loader #(
        .WIDTH           (WIDTH),
        .OP_WIDTH        (OP_WIDTH),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {a, b, op, out_valid, state}
    logic [13:0] obs;
    assign obs = {bus.a, bus.b, bus.op, bus.out_valid, bus.state};

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Clean press: btn high long enough to debounce, then released long
    // enough for the low level to debounce too.
    task automatic press_clean(input logic [3:0] val);
        bus.sw  = val;
        tick(3);
        bus.btn = 1'b1;
        tick(DB + 4);
        bus.btn = 1'b0;
        tick(DB + 4);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.btn = 1'b0;
        bus.out_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.btn = 1'b1;
        bus.sw = 4'hF;
        bus.out_ready = 1'b0;
        tick(2);
        vectors++;
        if (obs !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_hold: got %h expected %h", obs, 14'h0);
        end
        rst = 1'b0;
        tick(1);
        vectors++;
        if (obs !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_first_edge: got %h expected %h", obs, 14'h0);
        end
        bus.btn = 1'b0;
        tick(12);
        vectors++;
        if (obs !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_settle: got %h expected %h", obs, 14'h0);
        end
    endtask

    task automatic test_full_sequence();
        logic [13:0] exp;
        press_clean(4'h5);
        vectors++;
        exp = {4'h5, 4'h0, 3'd0, 1'b0, 2'd1};
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL seq_a: got %h expected %h", obs, exp);
        end
        press_clean(4'h3);
        vectors++;
        exp = {4'h5, 4'h3, 3'd0, 1'b0, 2'd2};
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL seq_b: got %h expected %h", obs, exp);
        end
        press_clean(4'h1);
        exp = {4'h5, 4'h3, 3'd1, 1'b1, 2'd3};
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL seq_issue_hold cyc %0d: got %h expected %h", i, obs, exp);
            end
            tick(1);
        end
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        vectors++;
        exp = {4'h5, 4'h3, 3'd1, 1'b0, 2'd0};
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL seq_accept: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_latency();
        logic [13:0] exp;
        bus.sw = 4'h9;
        tick(3);
        bus.btn = 1'b1;     // first sampled at the next edge (edge 1)
        tick(DB + 2);       // through edge 6
        vectors++;
        exp = {4'h5, 4'h3, 3'd1, 1'b0, 2'd0};
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL latency_edge6: got %h expected %h", obs, exp);
        end
        tick(1);            // edge 7
        vectors++;
        exp = {4'h9, 4'h3, 3'd1, 1'b0, 2'd1};
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL latency_edge7: got %h expected %h", obs, exp);
        end
        bus.btn = 1'b0;
        tick(DB + 4);
    endtask

    task automatic test_bounce();
        logic [3:0]  pat;
        logic [13:0] exp;
        do_reset();
        bus.sw = 4'h6;
        pat = 4'b0111;      // applied LSB first: 1,1,1,0
        for (int i = 0; i < 40; i++) begin
            bus.btn = pat[i % 4];
            tick(1);
        end
        bus.btn = 1'b0;
        tick(DB + 4);
        vectors++;
        exp = 14'h0;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL bounce_no_capture: got %h expected %h", obs, exp);
        end
        bus.btn = 1'b1;
        tick(60);
        vectors++;
        exp = {4'h6, 4'h0, 3'd0, 1'b0, 2'd1};
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL bounce_hold_once: got %h expected %h", obs, exp);
        end
        bus.btn = 1'b0;
        tick(DB + 4);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL bounce_release_no_event: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_ignore_in_issue();
        logic [13:0] exp;
        do_reset();
        press_clean(4'h2);
        press_clean(4'h4);
        press_clean(4'h6);
        exp = {4'h2, 4'h4, 3'd6, 1'b1, 2'd3};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL ignore_setup: got %h expected %h", obs, exp);
        end
        press_clean(4'hA);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL ignore_press: got %h expected %h", obs, exp);
        end
        // Press pulse is high between edges 6 and 7; out_ready meets it at edge 7.
        bus.btn = 1'b1;
        tick(DB + 2);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        exp = {4'h2, 4'h4, 3'd6, 1'b0, 2'd0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL ignore_with_ready: got %h expected %h", obs, exp);
        end
        bus.btn = 1'b0;
        tick(DB + 4);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL ignore_after_ready: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_mid_reset();
        logic [13:0] exp;
        do_reset();
        press_clean(4'h7);
        press_clean(4'h2);
        exp = {4'h7, 4'h2, 3'd0, 1'b0, 2'd2};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL midrst_setup: got %h expected %h", obs, exp);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        vectors++;
        if (obs !== 14'h0) begin
            miscompares++;
            $display("FAIL midrst_clear: got %h expected %h", obs, 14'h0);
        end
        press_clean(4'hC);
        exp = {4'hC, 4'h0, 3'd0, 1'b0, 2'd1};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL midrst_recapture: got %h expected %h", obs, exp);
        end
    endtask

    initial begin
        bus.sw = '0;
        bus.btn = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_full_sequence();
        test_latency();
        test_bounce();
        test_ignore_in_issue();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
Front-end stage that feeds the 4-bit ALU on the board. The user sets operand A, operand B and the opcode one after another on the slide switches. Each value is committed with a single push-button. Each raw button press is synchronised, debounced and turned into one press event. The block holds the three committed values stable and presents them to the ALU with a valid/ready handshake.

Parameters:
WIDTH, 4, operand width in bits
OP_WIDTH, 3, opcode width in bits; must be <= WIDTH
DEBOUNCE_CYCLES, 1000000, number of consecutive stable cycles needed to accept a button level change (benches override to 4); must be >= 2

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous reset, active-high
sw  in  WIDTH  raw slide switches, asynchronous to clk
btn  in  1  raw push-button, asynchronous, bouncy
a  out  WIDTH  committed operand A (registered)
b  out  WIDTH  committed operand B (registered)
op  out  OP_WIDTH  committed opcode (registered)
out_valid  out  1  a/b/op form a complete request
out_ready  in  1  ALU stage accepts the request
state  out  2  current step, for LEDs: 0=A, 1=B, 2=OP, 3=ISSUE

Behaviour:
- Reset is synchronous and active-high. While rst=1 on an edge:
  - a, b, op and out_valid go to 0; state goes to S_A.
  - Synchroniser flops, debounced level db, db_d and the debounce counter cnt all go to 0.
  - Reset asserted in any state, including mid-sequence or during ISSUE, discards all progress.
- Synchronisers: btn and sw each pass through a 2-flop synchroniser, giving btn_s and sw_s.
  - Values are captured from sw_s, i.e. the switch value from 2 cycles earlier.
- Debounce:
  - If btn_s == db, cnt <= 0.
  - Otherwise, if cnt == DEBOUNCE_CYCLES-1, then db <= btn_s and cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - cnt width is clog2(DEBOUNCE_CYCLES). cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
  - Any btn_s glitch shorter than DEBOUNCE_CYCLES cycles restarts the count and leaves db unchanged.
- Press event: db_d is db delayed one cycle; press = db & ~db_d (combinational).
  - press lasts exactly 1 cycle per debounced rising edge.
  - Releasing the button produces no event. Holding it produces exactly one event.
- Latency: if raw btn is first sampled high at edge 1 and stays high, the FSM captures on edge DEBOUNCE_CYCLES+3.
- FSM (registered state, encoding 0..3):
  - S_A: on press, a <= sw_s; go to S_B.
  - S_B: on press, b <= sw_s; go to S_OP.
  - S_OP: on press, op <= sw_s[OP_WIDTH-1:0]; out_valid <= 1; go to S_ISSUE.
  - S_ISSUE: out_valid held at 1 and a/b/op held stable.
    - If out_ready=1 on an edge, the transfer completes: out_valid <= 0 and state goes to S_A.
    - a/b/op keep their values until overwritten by the next sequence.
    - press is ignored in S_ISSUE, including a press in the same cycle as out_ready.
- out_valid is never deasserted without out_ready=1 or rst=1.
- out_ready is ignored outside S_ISSUE.
- In S_A/S_B/S_OP, a/b/op change only on the press that captures them.

Decomposition:
- Package alu_pkg holds:
  - State encoding constants S_A=2'd0, S_B=2'd1, S_OP=2'd2, S_ISSUE=2'd3.
  - Opcode constants shared with the ALU: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT_A=5, SHL=6, SHR=7.
- One sub-module, btn_debounce (params DEBOUNCE_CYCLES; ports clk, rst, btn, press):
  - Contains the btn synchroniser, cnt, db, db_d and press.
  - The sw synchroniser and the FSM stay in alu_operand_loader.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4.)
1. Reset: hold rst=1 for 2 cycles with btn=1 and sw=4'hF -> a=0, b=0, op=0, out_valid=0, state=0. No capture occurs on the first edge after rst falls.
2. Full sequence: sw=4'h5 and clean press; sw=4'h3 and press; sw=4'h1 and press; out_ready=0 -> a=5, b=3, op=1, out_valid=1, state=3, held for 20 cycles. Then out_ready=1 for 1 cycle -> next edge out_valid=0, state=0, a=5 still.
3. Latency: btn rises and is first sampled at edge 1 -> a updates exactly at edge 7, not at edge 6.
4. Bounce: btn pattern 1,1,1,0,1,1,1,0 repeated for 40 cycles, then 0 -> no capture and state stays 0. Then btn held at 1 for 60 cycles -> exactly one capture (state=1, not 2).
5. Ignore in ISSUE: in S_ISSUE with out_ready=0, sw=4'hA and a clean press -> a, b and op unchanged, state=3. Press coinciding with out_ready=1 -> state=0 and a unchanged.
6. Mid-sequence reset: in S_OP with a=7, b=2, assert rst for 1 cycle -> a=0, b=0, state=0, out_valid=0. A following press captures into a.
